// File: rtl/lighthouse_sync_decode.sv
// lighthouse_sync_decode
// Classifies the two sync pulse lengths of each sweep-timer triple into
// {skip, data, axis} codes, picks the non-skipping base station and emits a
// range-checked, station/axis-tagged sweep two cycles after sweep_strobe.
//
// Optional feature macro: LIGHTHOUSE_OOTX_EN
//   defined   -> one OOTX deframer per station plus a one-entry holding
//                register that serialises same-cycle output from both.
//   undefined -> deframers are not built; the four ootx_* outputs are 0.
//
// Deframer states:
//   state | meaning
//   HUNT  | counting consecutive zero bits (saturates at 17) for a preamble
//   DATA  | emitting payload bits, 16 per word
//   SYNC  | expecting the sync bit after a word: 1 = next word, 0 = lost
module lighthouse_sync_decode #(
  parameter int WIDTH     = 24,
  parameter int SYNC_BASE = 3000,
  parameter int SYNC_STEP = 500,
  parameter int MAX_SWEEP = 400000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sync0,
  input  logic [WIDTH-1:0] sync1,
  input  logic [WIDTH-1:0] sweep,
  input  logic             sweep_strobe,
  output logic [WIDTH-1:0] sweep_out,
  output logic             station,
  output logic             axis,
  output logic             out_strobe,
  output logic             err_strobe,
  output logic             ootx_bit,
  output logic             ootx_station,
  output logic             ootx_bit_strobe,
  output logic             ootx_frame_start
);

  // Bin edges sit half a step either side of each code centre, so compare
  // 2*len against 2*BASE + (2k-1)*STEP to stay in integers. Returns {valid, n}.
  function automatic logic [3:0] classify(input logic [WIDTH-1:0] len);
    logic [WIDTH+1:0] len2;
    logic [3:0]       r;
    len2 = {1'b0, len, 1'b0};
    r    = 4'b0;
    for (int k = 0; k < 8; k++) begin
      if (len2 >= (WIDTH+2)'(2*SYNC_BASE + (2*k-1)*SYNC_STEP))
        r = {1'b1, 3'(k)};
    end
    if (len2 >= (WIDTH+2)'(2*SYNC_BASE + 15*SYNC_STEP))
      r = 4'b0;
    return r;
  endfunction

  logic [3:0]       cls0, cls1;
  logic             s1_valid, s1_v0, s1_v1, s1_range_ok;
  logic [2:0]       s1_code0, s1_code1;
  logic [WIDTH-1:0] s1_sweep;
  logic             sel_ok, sel_st;

  assign cls0 = classify(sync0);
  assign cls1 = classify(sync1);

  // Stage 1: register codes, valid flags and the sweep range check
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_v0       <= 1'b0;
      s1_v1       <= 1'b0;
      s1_code0    <= '0;
      s1_code1    <= '0;
      s1_range_ok <= 1'b0;
      s1_sweep    <= '0;
    end else begin
      s1_valid    <= sweep_strobe;
      s1_v0       <= cls0[3];
      s1_v1       <= cls1[3];
      s1_code0    <= cls0[2:0];
      s1_code1    <= cls1[2:0];
      s1_range_ok <= (sweep < WIDTH'(MAX_SWEEP));
      s1_sweep    <= sweep;
    end
  end

  // Exactly one station may be non-skipping; station 0 skipping means station 1 is active.
  assign sel_ok = s1_v0 & s1_v1 & (s1_code0[2] ^ s1_code1[2]) & s1_range_ok;
  assign sel_st = s1_code0[2];

  // Stage 2: accept or reject the triple; data outputs hold between accepts
  always_ff @(posedge clk) begin
    if (reset) begin
      out_strobe <= 1'b0;
      err_strobe <= 1'b0;
      sweep_out  <= '0;
      station    <= 1'b0;
      axis       <= 1'b0;
    end else begin
      out_strobe <= s1_valid & sel_ok;
      err_strobe <= s1_valid & ~sel_ok;
      if (s1_valid && sel_ok) begin
        sweep_out <= s1_sweep;
        station   <= sel_st;
        axis      <= sel_st ? s1_code1[0] : s1_code0[0];
      end
    end
  end

`ifdef LIGHTHOUSE_OOTX_EN
  typedef enum logic [1:0] {HUNT, DATA, SYNC} df_state_e;

  typedef struct packed {
    df_state_e  st;
    logic [4:0] cnt;
    logic       emit;
    logic       fstart;
  } df_step_t;

  // One deframer step for a single incoming data bit; cnt counts zeros in
  // HUNT and payload bits in DATA.
  function automatic df_step_t df_step(input df_state_e st, input logic [4:0] cnt,
                                       input logic valid, input logic bit_in);
    df_step_t r;
    r.st     = st;
    r.cnt    = cnt;
    r.emit   = 1'b0;
    r.fstart = 1'b0;
    if (!valid) begin
      r.st  = HUNT;
      r.cnt = '0;
    end else begin
      case (st)
        HUNT: begin
          if (!bit_in) begin
            r.cnt = (cnt >= 5'd17) ? 5'd17 : cnt + 5'd1;
          end else begin
            if (cnt >= 5'd17) begin
              r.fstart = 1'b1;
              r.st     = DATA;
            end
            r.cnt = '0;
          end
        end
        DATA: begin
          r.emit = 1'b1;
          if (cnt == 5'd15) begin
            r.st  = SYNC;
            r.cnt = '0;
          end else begin
            r.cnt = cnt + 5'd1;
          end
        end
        SYNC: begin
          if (bit_in) begin
            r.st  = DATA;
            r.cnt = '0;
          end else begin
            r.st  = HUNT;
            r.cnt = 5'd1;
          end
        end
        default: begin
          r.st  = HUNT;
          r.cnt = '0;
        end
      endcase
    end
    return r;
  endfunction

  df_state_e  df_st0, df_st1;
  logic [4:0] df_cnt0, df_cnt1;
  df_step_t   step0, step1;
  logic       ev0, ev1;
  logic       hold_valid, hold_emit, hold_fs, hold_bit;

  assign step0 = df_step(df_st0, df_cnt0, s1_v0, s1_code0[1]);
  assign step1 = df_step(df_st1, df_cnt1, s1_v1, s1_code1[1]);
  assign ev0   = step0.emit | step0.fstart;
  assign ev1   = step1.emit | step1.fstart;

  // Deframer states plus OOTX output serialisation (station 0 first, station 1 via hold)
  always_ff @(posedge clk) begin
    if (reset) begin
      df_st0           <= HUNT;
      df_st1           <= HUNT;
      df_cnt0          <= '0;
      df_cnt1          <= '0;
      hold_valid       <= 1'b0;
      hold_emit        <= 1'b0;
      hold_fs          <= 1'b0;
      hold_bit         <= 1'b0;
      ootx_bit         <= 1'b0;
      ootx_station     <= 1'b0;
      ootx_bit_strobe  <= 1'b0;
      ootx_frame_start <= 1'b0;
    end else begin
      ootx_bit_strobe  <= 1'b0;
      ootx_frame_start <= 1'b0;
      if (s1_valid) begin
        df_st0  <= step0.st;
        df_cnt0 <= step0.cnt;
        df_st1  <= step1.st;
        df_cnt1 <= step1.cnt;
        if (ev0) begin
          ootx_station     <= 1'b0;
          ootx_bit_strobe  <= step0.emit;
          ootx_frame_start <= step0.fstart;
          if (step0.emit)
            ootx_bit <= s1_code0[1];
          if (ev1) begin
            hold_valid <= 1'b1;
            hold_emit  <= step1.emit;
            hold_fs    <= step1.fstart;
            hold_bit   <= s1_code1[1];
          end
        end else if (ev1) begin
          ootx_station     <= 1'b1;
          ootx_bit_strobe  <= step1.emit;
          ootx_frame_start <= step1.fstart;
          if (step1.emit)
            ootx_bit <= s1_code1[1];
        end
      end else if (hold_valid) begin
        hold_valid       <= 1'b0;
        ootx_station     <= 1'b1;
        ootx_bit_strobe  <= hold_emit;
        ootx_frame_start <= hold_fs;
        if (hold_emit)
          ootx_bit <= hold_bit;
      end
    end
  end
`else
  logic unused_data;
  assign unused_data      = s1_code0[1] ^ s1_code1[1];
  assign ootx_bit         = 1'b0;
  assign ootx_station     = 1'b0;
  assign ootx_bit_strobe  = 1'b0;
  assign ootx_frame_start = 1'b0;
`endif

endmodule

// File: tb/tb_lighthouse_sync_decode.sv
// Bench for lighthouse_sync_decode: directed test-plan steps followed by
// random triples, all checked against an arithmetic reference model.
module tb_lighthouse_sync_decode;
  localparam int BASE = 3000;
  localparam int STEP = 500;
  localparam int MAXS = 400000;
`ifdef LIGHTHOUSE_OOTX_EN
  localparam bit OOTX_EN = 1'b1;
`else
  localparam bit OOTX_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] sync0 = '0, sync1 = '0, sweep = '0;
  logic        sweep_strobe = 1'b0;
  logic [23:0] sweep_out;
  logic        station, axis, out_strobe, err_strobe;
  logic        ootx_bit, ootx_station, ootx_bit_strobe, ootx_frame_start;

  lighthouse_sync_decode dut (
    .clk(clk), .reset(reset), .sync0(sync0), .sync1(sync1), .sweep(sweep),
    .sweep_strobe(sweep_strobe), .sweep_out(sweep_out), .station(station),
    .axis(axis), .out_strobe(out_strobe), .err_strobe(err_strobe),
    .ootx_bit(ootx_bit), .ootx_station(ootx_station),
    .ootx_bit_strobe(ootx_bit_strobe), .ootx_frame_start(ootx_frame_start)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // reference model state
  logic [23:0] m_sweep;
  bit m_station, m_axis, m_obit, m_ostation;
  int zeros [2];
  bit inframe [2];
  int pos [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sweep = '0; m_station = 0; m_axis = 0; m_obit = 0; m_ostation = 0;
    for (int s = 0; s < 2; s++) begin
      zeros[s] = 0; inframe[s] = 0; pos[s] = 0;
    end
  endtask

  // code index from length by plain arithmetic, -1 when out of range
  function automatic int code_of(input int len);
    if (2*len < 2*BASE - STEP || 2*len >= 2*BASE + 15*STEP) return -1;
    return (2*len - 2*BASE + STEP) / (2*STEP);
  endfunction

  function automatic int len_for(input int n);
    return BASE + n*STEP + int'($urandom_range(0, 499)) - 250;
  endfunction

  // ev: 0 none, 1 frame start, 2 payload bit
  task automatic df_model(input int s, input int n, output int ev, output bit b);
    ev = 0;
    b  = (n >= 0) ? n[1] : 1'b0;
    if (n < 0) begin
      inframe[s] = 0; zeros[s] = 0;
    end else if (!inframe[s]) begin
      if (!b) zeros[s]++;
      else begin
        if (zeros[s] >= 17) begin inframe[s] = 1; pos[s] = 0; ev = 1; end
        zeros[s] = 0;
      end
    end else if (pos[s] < 16) begin
      ev = 2; pos[s]++;
    end else begin
      if (b) pos[s] = 0;
      else begin inframe[s] = 0; zeros[s] = 1; end
    end
  endtask

  task automatic apply_ev(input int s, input int ev, input bit b);
    m_ostation = s[0];
    if (ev == 2) m_obit = b;
  endtask

  task automatic check_cycle(input string tag, input bit e_out, input bit e_err,
                             input bit e_bs, input bit e_fs);
    chk({tag, ".out_strobe"}, out_strobe, e_out);
    chk({tag, ".err_strobe"}, err_strobe, e_err);
    chk({tag, ".sweep_out"}, sweep_out, m_sweep);
    chk({tag, ".station"}, station, m_station);
    chk({tag, ".axis"}, axis, m_axis);
    chk({tag, ".ootx_bit_strobe"}, ootx_bit_strobe, OOTX_EN & e_bs);
    chk({tag, ".ootx_frame_start"}, ootx_frame_start, OOTX_EN & e_fs);
    chk({tag, ".ootx_bit"}, ootx_bit, OOTX_EN & m_obit);
    chk({tag, ".ootx_station"}, ootx_station, OOTX_EN & m_ostation);
  endtask

  task automatic send(input string tag, input int l0, input int l1, input int sw,
                      input bit rst_mid);
    int n0, n1, ev0, ev1;
    bit ok, b0, b1;
    n0 = code_of(l0);
    n1 = code_of(l1);
    ok = (n0 >= 0) && (n1 >= 0) && ((n0 >> 2) != (n1 >> 2)) && (sw < MAXS);
    @(negedge clk);
    sync0 = l0[23:0]; sync1 = l1[23:0]; sweep = sw[23:0]; sweep_strobe = 1'b1;
    @(negedge clk);
    sweep_strobe = 1'b0;
    if (rst_mid) reset = 1'b1;
    check_cycle({tag, "@1"}, 0, 0, 0, 0);
    if (rst_mid) begin
      model_reset();
      @(negedge clk); reset = 1'b0;
      check_cycle({tag, "@2"}, 0, 0, 0, 0);
      @(negedge clk); check_cycle({tag, "@3"}, 0, 0, 0, 0);
      @(negedge clk); check_cycle({tag, "@4"}, 0, 0, 0, 0);
      return;
    end
    df_model(0, n0, ev0, b0);
    df_model(1, n1, ev1, b1);
    if (ok) begin
      m_sweep   = sw[23:0];
      m_station = (n0 >> 2) != 0;
      m_axis    = m_station ? n1[0] : n0[0];
    end
    @(negedge clk);
    if (ev0 != 0) begin
      apply_ev(0, ev0, b0);
      check_cycle({tag, "@2"}, ok, !ok, ev0 == 2, ev0 == 1);
    end else begin
      if (ev1 != 0) apply_ev(1, ev1, b1);
      check_cycle({tag, "@2"}, ok, !ok, ev1 == 2, ev1 == 1);
    end
    @(negedge clk);
    if (ev0 != 0 && ev1 != 0) begin
      apply_ev(1, ev1, b1);
      check_cycle({tag, "@3"}, 0, 0, ev1 == 2, ev1 == 1);
    end else begin
      check_cycle({tag, "@3"}, 0, 0, 0, 0);
    end
    @(negedge clk);
    check_cycle({tag, "@4"}, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); @(negedge clk); reset = 1'b0;
    model_reset();
    check_cycle("reset", 0, 0, 0, 0);
  endtask

  initial begin
    logic [15:0] word;
    int d0, d1;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_cycle("reset", 0, 0, 0, 0);

    // basic selection
    send("st0_hit", 3000, 5000, 120000, 0);
    send("st1_ax1", 6000, 3500, 50000, 0);

    // boundaries
    send("len2749", 2749, 4500, 1000, 0);
    send("len6750", 3000, 6750, 1000, 0);
    send("len2750", 2750, 5000, 2000, 0);
    send("len6749", 6749, 3000, 3000, 0);
    send("len6749b", 6749, 3600, 3500, 0);
    send("sweep400000", 3000, 5000, 400000, 0);
    send("sweep399999", 3000, 5000, 399999, 0);

    // ambiguity
    send("both_n4", 5000, 5000, 7000, 0);
    send("both_n0", 3000, 3000, 7000, 0);

    // OOTX lock on station 0; station 1 skipping with data 0
    do_reset();
    word = 16'hA5C3;
    for (int i = 0; i < 17; i++) send("lock_pre", len_for(0), len_for(4), 1000 + i, 0);
    send("lock_one", len_for(2), len_for(4), 2000, 0);
    for (int i = 15; i >= 0; i--) send("lock_w0", len_for(word[i] ? 2 : 0), len_for(4), 3000, 0);
    send("lock_sync1", len_for(3), len_for(4), 4000, 0);
    for (int i = 0; i < 16; i++) send("lock_w1", len_for($urandom_range(0, 1) ? 2 : 0), len_for(5), 5000, 0);
    send("lock_sync0", len_for(1), len_for(4), 6000, 0);
    send("hunt_one", len_for(2), len_for(4), 6500, 0);

    // both stations lock together, then emit concurrently
    do_reset();
    for (int i = 0; i < 17; i++) send("dual_pre", len_for(0), len_for(4), 100, 0);
    send("dual_one", len_for(2), len_for(6), 200, 0);
    for (int i = 0; i < 20; i++) begin
      d0 = $urandom_range(0, 1);
      d1 = $urandom_range(0, 1);
      send("dual_bits", len_for(2*d0), len_for(4 + 2*d1), $urandom_range(0, MAXS - 1), 0);
    end

    // reset in the middle of the pipeline, then coincident with a strobe
    send("rst_mid", 3000, 5000, 9000, 1);
    send("after_rst", 3500, 6000, 9100, 0);
    @(negedge clk);
    reset = 1'b1; sync0 = 24'd3000; sync1 = 24'd5000; sweep = 24'd9200; sweep_strobe = 1'b1;
    @(negedge clk);
    reset = 1'b0; sweep_strobe = 1'b0;
    model_reset();
    check_cycle("rst_coinc@1", 0, 0, 0, 0);
    @(negedge clk); check_cycle("rst_coinc@2", 0, 0, 0, 0);
    @(negedge clk); check_cycle("rst_coinc@3", 0, 0, 0, 0);

    // random triples
    for (int i = 0; i < 80; i++) begin
      int l0, l1, sw;
      l0 = $urandom_range(2600, 6900);
      l1 = $urandom_range(2600, 6900);
      sw = ($urandom_range(0, 3) == 0) ? MAXS - 2 + int'($urandom_range(0, 3))
                                       : int'($urandom_range(0, MAXS - 1));
      send("random", l0, l1, sw, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lighthouse_sync_decode.md
# lighthouse_sync_decode

Downstream consumer of the lighthouse sweep timer. It takes each `{sync0, sync1, sweep}` triple and its strobe, and classifies both sync-pulse lengths into skip/data/axis fields. It selects the non-skipping base station and emits a tagged, range-checked sweep measurement. Optionally it deframes each station's OOTX data bits into a bit stream for a later OOTX packet parser. It sits between the sweep timer and the timer FIFO / UART formatter in the top level.

## Interface
Parameters:
- `WIDTH`, 24: width of the sync/sweep inputs and of `sweep_out`.
- `SYNC_BASE`, 3000: clocks for sync code n=0 (62.5 µs at 48 MHz).
- `SYNC_STEP`, 500: clocks per code step (10.42 µs at 48 MHz).
- `MAX_SWEEP`, 400000: largest valid sweep in clocks (8.33 ms at 48 MHz).

Ports:
- `clk`, in, 1: 48 MHz system clock.
- `reset`, in, 1: synchronous, active-high.
- `sync0`, in, WIDTH: first sync pulse length (station 0).
- `sync1`, in, WIDTH: second sync pulse length (station 1).
- `sweep`, in, WIDTH: sweep time in clocks.
- `sweep_strobe`, in, 1: one-cycle strobe; the inputs are valid in that cycle.
- `sweep_out`, out, WIDTH: validated sweep.
- `station`, out, 1: 0 means sync0 was the active station, 1 means sync1.
- `axis`, out, 1: axis bit of the active station's code.
- `out_strobe`, out, 1: one-cycle strobe for a valid measurement.
- `err_strobe`, out, 1: one-cycle strobe for a rejected triple.
- `ootx_bit`, out, 1: deframed OOTX payload bit.
- `ootx_station`, out, 1: station that owns `ootx_bit` / `ootx_frame_start`.
- `ootx_bit_strobe`, out, 1: one cycle per payload bit.
- `ootx_frame_start`, out, 1: one cycle when a preamble is recognised.

## Operation
- Code classification: n = k when `SYNC_BASE + (k-0.5)*SYNC_STEP <= len < SYNC_BASE + (k+0.5)*SYNC_STEP`, for k = 0..7.
  - The lower bound is inclusive and the upper bound exclusive.
  - A length outside [2750, 6750) at the defaults is invalid.
  - The field layout is n = {skip, data, axis}.
  - Classification uses a constant-compare chain only; no divider.
- Selection, applied when both codes are valid:
  - Exactly one code with skip=0: that code is active. `station` is its index, `axis` is its axis bit, `sweep_out` = `sweep`, and `out_strobe` pulses.
  - Both skip, neither skip, either code invalid, or `sweep` >= `MAX_SWEEP`: `err_strobe` pulses and `out_strobe` stays low.
- OOTX: each valid sync code delivers its data bit to that station's deframer. An invalid code forces that station's deframer to HUNT with its zero count cleared.
- Deframer FSM, one per station:
  - HUNT: count consecutive 0 bits, saturating at 17. A 1 with count >= 17 pulses `ootx_frame_start` and moves to DATA with the bit count at 0. A 1 with count < 17 resets the count.
  - DATA: emit each bit on `ootx_bit` with `ootx_bit_strobe`. After 16 bits go to SYNC.
  - SYNC: a 1 returns to DATA with the bit count cleared and is not emitted. A 0 returns to HUNT with the zero count set to 1.
- Both deframers run every strobe. When both produce output in the same cycle, station 0 is presented first and station 1 the following cycle, through a one-entry holding register. The next `sweep_strobe` cannot arrive within 2 cycles (sync pulses are ≥ 57 µs), so the holding register never overflows.

## Timing
- Reset values: all strobes 0, `sweep_out`/`station`/`axis`/`ootx_bit`/`ootx_station` 0, both deframers in HUNT with count 0, holding register empty.
- Stage 1, cycle after `sweep_strobe`: registers the two codes, their valid flags and the sweep range check.
- Stage 2, second cycle after `sweep_strobe`: `out_strobe` or `err_strobe` pulses, and station 0's OOTX outputs pulse. Station 1's OOTX output pulses in the same cycle if station 0 has none, otherwise one cycle later.
- Latency to `out_strobe`/`err_strobe` is exactly 2 cycles.
- `out_strobe` and `err_strobe` are mutually exclusive. Data outputs hold their values until the next strobe.
- `reset` asserted in any cycle clears pipeline stages, deframer states and the holding register in that same edge. A `sweep_strobe` coincident with `reset` is dropped.

## Configuration
- `LIGHTHOUSE_OOTX_EN` defined: deframers and OOTX outputs are present as described.
- `LIGHTHOUSE_OOTX_EN` undefined: deframers and the holding register are not built, and the four OOTX outputs are tied to 0. Sweep classification and selection, including their 2-cycle latency, are unchanged.

## Test plan
- Basic station 0 hit: `sync0`=3000 (n=0), `sync1`=5000 (n=4), `sweep`=120000, strobe → 2 cycles later `out_strobe`=1, `station`=0, `axis`=0, `sweep_out`=120000.
- Station 1, axis 1: `sync0`=6000 (n=6), `sync1`=3500 (n=1), `sweep`=50000 → `out_strobe`, `station`=1, `axis`=1.
- Boundaries: lengths 2749 and 6750 → `err_strobe`; 2750 → n=0 and 6749 → n=7 accepted. `sweep`=400000 → `err_strobe`; 399999 → `out_strobe`.
- Ambiguity: both n=4, and separately both n=0 → `err_strobe` only, no `out_strobe`.
- OOTX lock: feed station 0 data bits of 17 zeros, 1, 16 payload bits 0xA5C3 (MSB first), a sync bit of 1, then a sync bit of 0 after the next 16 bits →
  - one `ootx_frame_start`, then 0xA5C3 on `ootx_bit` with 16 strobes;
  - the first sync bit is not emitted;
  - the 0 sync bit returns the deframer to HUNT.
- Concurrent bits and reset:
  - Both deframers emit in the same strobe → station 0 at +2 cycles, station 1 at +3 cycles.
  - `reset` asserted at +1 cycle → no strobes and no OOTX output from that triple.
